// File: rtl/counter_pkg.sv
// Shared definitions for the counter/adder datapath: FSM state codes and default width.
package counter_pkg;

  localparam int DEFAULT_WIDTH = 5;

  typedef enum logic [1:0] {
    CNT_IDLE = 2'b00,
    CNT_RUN  = 2'b01,
    CNT_DONE = 2'b10
  } cnt_state_e;

endpackage

// File: rtl/down_cell.sv
// One bit of the down counter: parallel load has priority over toggle-on-borrow.
module down_cell import counter_pkg::*; (
  input  logic clk,
  input  logic clear,
  input  logic load,
  input  logic d,
  input  logic toggle,
  output logic q
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge clear) begin
    if (clear)       q <= 1'b0;
    else if (load)   q <= d;
    else if (toggle) q <= ~q;
  end

endmodule

// File: rtl/load_down_counter.sv
// Presettable down counter / countdown timer with optional auto-reload for periodic ticks.
module load_down_counter import counter_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             load,
  input  logic             count_permission,
  input  logic             auto_reload,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] contagem,
  output logic [WIDTH-1:0] saida,
  output logic             busy,
  output logic             expired,
  output logic             done
);

  cnt_state_e       r_state, w_state_next;
  logic [WIDTH-1:0] r_reload;
  logic             r_done, w_done_next;
  logic             w_is_one, w_is_zero;
  logic             w_step, w_expire, w_count;
  logic             w_cell_load;
  logic [WIDTH-1:0] w_cell_data;

  assign w_is_one  = (contagem == WIDTH'(1));
  assign w_is_zero = (contagem == '0);

  assign w_step   = (r_state == CNT_RUN) && !load && count_permission;
  assign w_expire = w_step && w_is_one;
  // The zero guard keeps the chain from ever borrowing out into all ones.
  assign w_count  = w_step && !w_is_zero && !(w_is_one && auto_reload);

  assign w_cell_load = load || (w_expire && auto_reload);
  assign w_cell_data = load ? load_data : r_reload;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    logic w_lower_zero;
    if (i == 0) begin : g_lsb
      assign w_lower_zero = 1'b1;
    end else begin : g_upper
      assign w_lower_zero = (contagem[i-1:0] == '0);
    end

    down_cell u_cell (
      .clk    (clk),
      .clear  (clear),
      .load   (w_cell_load),
      .d      (w_cell_data[i]),
      .toggle (w_count && w_lower_zero),
      .q      (contagem[i])
    );
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear)     r_reload <= '0;
    else if (load) r_reload <= load_data;
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_state <= CNT_IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_done  <= w_done_next;
    end
  end

  // NOTE: every variable written here gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_done_next  = 1'b0;
    if (load) begin
      w_state_next = (load_data != '0) ? CNT_RUN : CNT_IDLE;
    end else if (w_expire) begin
      w_done_next = 1'b1;
      if (!auto_reload) w_state_next = CNT_DONE;
    end
  end

  assign busy    = (r_state == CNT_RUN);
  assign expired = (r_state == CNT_DONE);
  assign done    = r_done;
  assign saida   = ~contagem;

endmodule

// File: tb/tb_load_down_counter.sv
// Directed scenarios plus randomized stimulus against a behavioural countdown-timer model.
module tb_load_down_counter;

  localparam int W    = 5;
  localparam int MASK = (1 << W) - 1;
  localparam int ST_IDLE = 0, ST_RUN = 1, ST_DONE = 2;

  logic         clk = 1'b0;
  logic         clear = 1'b1;
  logic         load = 1'b0;
  logic         count_permission = 1'b0;
  logic         auto_reload = 1'b0;
  logic [W-1:0] load_data = '0;
  logic [W-1:0] contagem, saida;
  logic         busy, expired, done;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: count value, reload value, phase, done pulse.
  int m_cnt = 0, m_rel = 0, m_st = ST_IDLE;
  bit m_dn = 1'b0;

  load_down_counter #(.WIDTH(W)) dut (
    .clk              (clk),
    .clear            (clear),
    .load             (load),
    .count_permission (count_permission),
    .auto_reload      (auto_reload),
    .load_data        (load_data),
    .contagem         (contagem),
    .saida            (saida),
    .busy             (busy),
    .expired          (expired),
    .done             (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    check("contagem", 32'(contagem), m_cnt);
    check("saida", 32'(saida), (~m_cnt) & MASK);
    check("busy", 32'(busy), (m_st == ST_RUN) ? 1 : 0);
    check("expired", 32'(expired), (m_st == ST_DONE) ? 1 : 0);
    check("done", 32'(done), m_dn ? 1 : 0);
  endtask

  // Apply one set of inputs across one rising edge, advance the model, and compare.
  task automatic step(input bit ld, input bit cp, input bit ar, input int d);
    @(negedge clk);
    load = ld; count_permission = cp; auto_reload = ar; load_data = W'(d);
    @(posedge clk);
    m_dn = 1'b0;
    if (ld) begin
      m_cnt = d & MASK;
      m_rel = d & MASK;
      m_st  = (m_cnt != 0) ? ST_RUN : ST_IDLE;
    end else if (m_st == ST_RUN && cp) begin
      if (m_cnt > 1) begin
        m_cnt = m_cnt - 1;
      end else if (ar) begin
        m_cnt = m_rel;
        m_dn  = 1'b1;
      end else begin
        m_cnt = 0;
        m_dn  = 1'b1;
        m_st  = ST_DONE;
      end
    end
    #1;
    check_all();
  endtask

  // Pulse clear between edges; outputs must drop immediately, without waiting for a clock.
  task automatic pulse_clear();
    @(negedge clk);
    load = 1'b0; count_permission = 1'b0;
    #2 clear = 1'b1;
    #1;
    m_cnt = 0; m_rel = 0; m_st = ST_IDLE; m_dn = 1'b0;
    check("clr_contagem", 32'(contagem), 0);
    check("clr_saida", 32'(saida), 32'h1f);
    check("clr_busy", 32'(busy), 0);
    check("clr_expired", 32'(expired), 0);
    check("clr_done", 32'(done), 0);
    @(negedge clk);
    clear = 1'b0;
  endtask

  initial begin
    #12;
    check_all();
    clear = 1'b0;

    // Reset mid-run at contagem 9.
    step(1, 0, 0, 12);
    repeat (3) step(0, 1, 0, 0);
    check("pre_clear_9", 32'(contagem), 9);
    pulse_clear();

    // One-shot from 3, with extra counts after expiry.
    step(1, 0, 0, 3);
    check("oneshot_load", 32'(contagem), 3);
    repeat (3) step(0, 1, 0, 0);
    check("oneshot_done", 32'(done), 1);
    repeat (3) step(0, 1, 0, 0);
    check("oneshot_hold0", 32'(contagem), 0);

    // Pause and resume.
    step(1, 0, 0, 5);
    repeat (2) step(0, 1, 0, 0);
    repeat (4) step(0, 0, 0, 0);
    check("pause_hold", 32'(contagem), 3);
    repeat (4) step(0, 1, 0, 0);

    // Load priority over counting, then load of zero.
    step(1, 1, 0, 20);
    check("load_prio", 32'(contagem), 20);
    step(1, 1, 0, 0);
    check("load_zero_busy", 32'(busy), 0);
    repeat (2) step(0, 1, 0, 0);

    // Auto-reload period of 4 edges.
    step(1, 0, 1, 4);
    repeat (13) step(0, 1, 1, 0);

    // Restart mid-count.
    step(1, 0, 0, 10);
    repeat (4) step(0, 1, 0, 0);
    step(1, 1, 0, 2);
    check("restart_val", 32'(contagem), 2);
    repeat (3) step(0, 1, 0, 0);

    // Randomized traffic; loads are kept sparse so counts actually run down.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        pulse_clear();
      end else begin
        step($urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0,
             $urandom_range(0, 1) == 1,
             ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 8)));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
